// File: rtl/udp_pkg.sv
// Constants and encodings shared by the UDP transmit and receive buffers.
package udp_pkg;

   localparam logic [31:0] FRAME_HEAD = 32'hF3ED7A93;
   localparam logic [31:0] FRAME_TAIL = 32'hF3ED7A94;

   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StReq  = 2'b01,
      StSend = 2'b10
   } tx_state_e;

   typedef enum logic [1:0] {
      PktHead = 2'b00,
      PktData = 2'b01,
      PktTail = 2'b10
   } pkt_type_e;

   // Byte idx of a 32-bit marker, MSB byte first.
   function automatic logic [7:0] marker_byte(input logic [31:0] marker, input logic [1:0] idx);
      return 8'(marker >> {~idx, 3'b000});
   endfunction

endpackage

// File: rtl/udp_tx_fifo.sv
// Synchronous first-word-fall-through FIFO with synchronous clear and fill level.
module udp_tx_fifo #(
   parameter int unsigned AW = 11,
   parameter int unsigned DW = 16
) (
   input  logic          app_rx_clk,
   input  logic          rstn,
   input  logic          sclr,
   input  logic          wr_en,
   input  logic [DW-1:0] din,
   input  logic          rd_en,
   output logic [DW-1:0] dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   level
);

   localparam logic [AW:0] DEPTH = (AW + 1)'(2 ** AW);

   logic [DW-1:0] mem [2 ** AW];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          do_wr;
   logic          do_rd;

   assign level = wr_ptr - rd_ptr;
   assign full  = (level == DEPTH);
   assign empty = (level == '0);
   assign do_wr = wr_en & ~full;
   assign do_rd = rd_en & ~empty;
   assign dout  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge app_rx_clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (sclr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + 1'b1;
         if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge app_rx_clk) begin
      if (do_wr) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/udp_tx_buf.sv
// Video-to-UDP packetiser: buffers a 16-bit pixel stream and emits HEAD, DATA and TAIL
// packets over the app_tx request/ack byte interface.
module udp_tx_buf
   import udp_pkg::*;
#(
   parameter int unsigned FRAME_PIXELS = 921600,
   parameter int unsigned PKT_BYTES    = 1024,
   parameter int unsigned FIFO_AW      = 11
) (
   input  logic        app_rx_clk,
   input  logic        rstn,
   input  logic        vid_vs,
   input  logic        vid_de,
   input  logic [15:0] vid_data,
   output logic        app_tx_data_request,
   input  logic        app_tx_ack,
   output logic [15:0] app_tx_data_length,
   output logic        app_tx_data_valid,
   output logic [7:0]  app_tx_data,
   output logic        fifo_overflow,
   output logic        frame_done
);

   localparam int unsigned PW = $clog2(FRAME_PIXELS + 1);

   tx_state_e        state_q, state_d;
   pkt_type_e        pkt_q, pkt_d;
   logic [15:0]      len_d;
   logic [15:0]      byte_cnt_q, byte_cnt_d;
   logic             vs_q, vs_rise;
   logic             flush_pend, head_pend, tail_pend;
   logic             flush_do, head_done, tail_done;
   logic [PW-1:0]    pix_cnt;
   logic             pix_ok, in_done;
   logic             fifo_rd, fifo_full, fifo_empty;
   logic [15:0]      fifo_dout;
   logic [FIFO_AW:0] level;

   assign vs_rise = vid_vs & ~vs_q;
   // Pixels arriving before the pending flush is serviced would be wiped anyway.
   assign pix_ok  = vid_de & ~flush_pend & ~vs_rise & (pix_cnt < PW'(FRAME_PIXELS));
   assign in_done = (pix_cnt == PW'(FRAME_PIXELS));

   udp_tx_fifo #(
      .AW (FIFO_AW),
      .DW (16)
   ) u_fifo (
      .app_rx_clk (app_rx_clk),
      .rstn       (rstn),
      .sclr       (flush_do),
      .wr_en      (pix_ok),
      .din        (vid_data),
      .rd_en      (fifo_rd),
      .dout       (fifo_dout),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .level      (level)
   );

   always_ff @(posedge app_rx_clk or negedge rstn) begin
      if (!rstn) begin
         vs_q          <= 1'b0;
         flush_pend    <= 1'b0;
         head_pend     <= 1'b0;
         tail_pend     <= 1'b0;
         fifo_overflow <= 1'b0;
         pix_cnt       <= '0;
      end else begin
         vs_q <= vid_vs;
         if (vs_rise)       flush_pend <= 1'b1;
         else if (flush_do) flush_pend <= 1'b0;
         if (flush_do)       head_pend <= 1'b1;
         else if (head_done) head_pend <= 1'b0;
         if (vs_rise)        tail_pend <= 1'b0;
         else if (flush_do)  tail_pend <= 1'b1;
         else if (tail_done) tail_pend <= 1'b0;
         if (vs_rise)                  fifo_overflow <= 1'b0;
         else if (pix_ok && fifo_full) fifo_overflow <= 1'b1;
         if (vs_rise)     pix_cnt <= '0;
         else if (pix_ok) pix_cnt <= pix_cnt + 1'b1;
      end
   end

   always_ff @(posedge app_rx_clk or negedge rstn) begin
      if (!rstn) begin
         state_q            <= StIdle;
         pkt_q              <= PktHead;
         app_tx_data_length <= '0;
         byte_cnt_q         <= '0;
      end else begin
         state_q            <= state_d;
         pkt_q              <= pkt_d;
         app_tx_data_length <= len_d;
         byte_cnt_q         <= byte_cnt_d;
      end
   end

   always_comb begin
      state_d             = state_q;
      pkt_d               = pkt_q;
      len_d               = app_tx_data_length;
      byte_cnt_d          = byte_cnt_q;
      flush_do            = 1'b0;
      head_done           = 1'b0;
      tail_done           = 1'b0;
      fifo_rd             = 1'b0;
      app_tx_data_request = 1'b0;
      app_tx_data_valid   = 1'b0;
      app_tx_data         = '0;
      frame_done          = 1'b0;
      unique case (state_q)
         StIdle: begin
            byte_cnt_d = '0;
            if (flush_pend) begin
               flush_do = 1'b1;
            end else if (head_pend) begin
               pkt_d   = PktHead;
               len_d   = 16'd4;
               state_d = StReq;
            end else if (32'(level) >= PKT_BYTES / 2) begin
               pkt_d   = PktData;
               len_d   = 16'(PKT_BYTES);
               state_d = StReq;
            end else if (in_done && !fifo_empty) begin
               pkt_d   = PktData;
               len_d   = 16'({level, 1'b0});
               state_d = StReq;
            end else if (in_done && tail_pend) begin
               pkt_d   = PktTail;
               len_d   = 16'd4;
               state_d = StReq;
            end
         end
         StReq: begin
            app_tx_data_request = 1'b1;
            if (app_tx_ack) state_d = StSend;
         end
         StSend: begin
            app_tx_data_valid = 1'b1;
            if (pkt_q == PktData) begin
               app_tx_data = byte_cnt_q[0] ? fifo_dout[7:0] : fifo_dout[15:8];
               fifo_rd     = byte_cnt_q[0];
            end else begin
               app_tx_data = marker_byte((pkt_q == PktTail) ? FRAME_TAIL : FRAME_HEAD,
                                         byte_cnt_q[1:0]);
            end
            byte_cnt_d = byte_cnt_q + 16'd1;
            if (byte_cnt_q == app_tx_data_length - 16'd1) begin
               state_d    = StIdle;
               head_done  = (pkt_q == PktHead);
               tail_done  = (pkt_q == PktTail);
               frame_done = tail_done;
            end
         end
         default: state_d = StIdle;
      endcase
   end

endmodule
